// File: rtl/bit_serial_alu_seq_if.sv
// Request/result bus of the bit-serial ALU sequencer.
// master = requester, slave = sequencer.
interface bit_serial_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             c_init;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  modport master (
    output start, op_code, opa, opb, c_init,
    input  busy, done, result, carry, zero
  );

  modport slave (
    input  start, op_code, opa, opb, c_init,
    output busy, done, result, carry, zero
  );
endinterface

// File: rtl/bit_serial_alu_seq.sv
// Feeds a 1-bit ALU one operand bit per clock, LSB first, and chains its carry.
// The serial output is assembled into a WIDTH-bit result with carry and zero flags.
module bit_serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bit_serial_alu_seq_if.slave   bus,
  output logic                  alu_a,
  output logic                  alu_b,
  output logic                  alu_c_in,
  output logic [2:0]            alu_op,
  input  logic                  alu_o,
  input  logic                  alu_c_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_acc;
  logic             r_cr;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_word;

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  // Final bit has not been shifted in yet; splice it in directly.
  assign w_word = {alu_o, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.result  = r_result;
    bus.carry   = r_carry;
    bus.zero    = r_zero;
    alu_a       = 1'b0;
    alu_b       = 1'b0;
    alu_c_in    = 1'b0;
    alu_op      = r_op;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        bus.busy = 1'b1;
        alu_a    = r_sa[0];
        alu_b    = r_sb[0];
        alu_c_in = r_cr;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_acc    <= '0;
      r_cr     <= 1'b0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sa  <= bus.opa;
            r_sb  <= bus.opb;
            r_op  <= bus.op_code;
            r_cr  <= bus.c_init;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_acc <= {alu_o, r_acc[WIDTH-1:1]};
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_cr  <= alu_c_out;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_word;
            r_carry  <= alu_c_out;
            r_zero   <= (w_word == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Directed bench for bit_serial_alu_seq with a behavioural 1-bit ALU
// (op 000 = full adder, op 001 = AND).
module tb_bit_serial_alu_seq;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alu_a, alu_b, alu_c_in;
  logic [2:0] alu_op;
  logic       alu_o, alu_c_out;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  bit_serial_alu_seq_if #(.WIDTH(W)) bus ();

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c_in  (alu_c_in),
    .alu_op    (alu_op),
    .alu_o     (alu_o),
    .alu_c_out (alu_c_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_o     = alu_a ^ alu_b ^ alu_c_in;
    alu_c_out = (alu_a & alu_b) | (alu_a & alu_c_in) | (alu_b & alu_c_in);
    if (alu_op == 3'b001) begin
      alu_o     = alu_a & alu_b;
      alu_c_out = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait (bounded) for done, check latency and flags.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic ci,
                        input logic [7:0] exp_res, input logic exp_cy, input logic exp_z);
    int unsigned lat;
    bus.opa = a; bus.opb = b; bus.op_code = op; bus.c_init = ci; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, W);
    chk({tag, "_res"}, bus.result, exp_res);
    chk({tag, "_cy"}, bus.carry, exp_cy);
    chk({tag, "_z"}, bus.zero, exp_z);
    tick();
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    logic [7:0]  a_seq;
    int unsigned d1, d2, n_done, cyc;
    logic [7:0]  r1, r2;

    bus.start = 1'b0; bus.op_code = '0; bus.opa = '0; bus.opb = '0; bus.c_init = 1'b0;

    // 1. async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_res", bus.result, 8'h00);
    chk("rst_cy", bus.carry, 1'b0);
    chk("rst_z", bus.zero, 1'b0);
    chk("rst_alu", {alu_a, alu_b, alu_c_in, alu_op}, 6'b0);
    tick();
    rst = 1'b0;
    tick();

    // 2. add 5A+3C with per-cycle checks
    a_seq = 8'h5A;
    bus.opa = 8'h5A; bus.opb = 8'h3C; bus.op_code = 3'b000; bus.c_init = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("add_busy%0d", i), bus.busy, 1'b1);
      chk($sformatf("add_done%0d", i), bus.done, 1'b0);
      chk($sformatf("add_alu_a%0d", i), alu_a, a_seq[i]);
      tick();
    end
    chk("add_done", bus.done, 1'b1);
    chk("add_busy_end", bus.busy, 1'b0);
    chk("add_res", bus.result, 8'h96);
    chk("add_cy", bus.carry, 1'b0);
    chk("add_z", bus.zero, 1'b0);
    tick();
    chk("add_done_clr", bus.done, 1'b0);
    chk("add_res_hold", bus.result, 8'h96);

    // 3. overflow and carry-in
    run_op("ovf", 8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("cin", 8'h10, 8'h20, 3'b000, 1'b1, 8'h31, 1'b0, 1'b0);

    // 4. AND pass-through with alu_op stable over the run
    bus.opa = 8'hF0; bus.opb = 8'h3C; bus.op_code = 3'b001; bus.c_init = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op_code = 3'b000;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("and_op%0d", i), alu_op, 3'b001);
      tick();
    end
    chk("and_done", bus.done, 1'b1);
    chk("and_res", bus.result, 8'h30);
    chk("and_cy", bus.carry, 1'b0);
    tick();

    // 5. start held high, operands changed during RUN
    bus.opa = 8'h5A; bus.opb = 8'h3C; bus.op_code = 3'b000; bus.c_init = 1'b0; bus.start = 1'b1;
    tick();
    bus.opa = 8'h01; bus.opb = 8'h02;
    n_done = 0; d1 = 0; d2 = 0; r1 = '0; r2 = '0; cyc = 0;
    while (n_done < 2 && cyc < 40) begin
      cyc++;
      if (bus.done) begin
        if (n_done == 0) begin d1 = cyc; r1 = bus.result; end
        else begin d2 = cyc; r2 = bus.result; end
        n_done++;
      end
      if (n_done < 2) tick();
    end
    bus.start = 1'b0;
    chk("hold_ndone", n_done, 2);
    chk("hold_res1", r1, 8'h96);
    chk("hold_res2", r2, 8'h03);
    chk("hold_gap", d2 - d1, 10);
    tick();
    tick();
    chk("hold_idle", bus.busy, 1'b0);

    // 6. abort mid-run with reset
    bus.opa = 8'h5A; bus.opb = 8'h3C; bus.op_code = 3'b000; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_res", bus.result, 8'h00);
    chk("abort_alu", {alu_a, alu_b, alu_c_in, alu_op}, 6'b0);
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) n_done++;
      tick();
    end
    chk("abort_nodone", n_done, 0);
    chk("abort_res_hold", bus.result, 8'h00);
    run_op("restart", 8'h5A, 8'h3C, 3'b000, 1'b0, 8'h96, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
